// File: rtl/regfile_read_arbiter.sv
// Round-robin read arbiter for four requesters sharing one 16-entry register read mux.
// Optional response timeout is enabled with the RDARB_TIMEOUT_EN macro.
module regfile_read_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [19:0] addr,
    input  logic        rready,
    input  logic [31:0] mux_out,
    output logic [4:0]  card,
    output logic [3:0]  gnt,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic [1:0]  rid,
    output logic        err,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [4:0]  card_q, card_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rid_q, rid_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;
`ifdef RDARB_TIMEOUT_EN
    logic [3:0]  cnt_q, cnt_d;
`endif

    logic [1:0]  winner_s;
    logic [1:0]  idx_s;
    logic        any_s;
    logic [4:0]  win_addr_s;

    // Round-robin search: scan offsets high to low so the closest requester above ptr wins.
    always_comb begin
        winner_s = ptr_q;
        any_s    = 1'b0;
        idx_s    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx_s = ptr_q + 2'(k);
            if (req[idx_s]) begin
                winner_s = idx_s;
                any_s    = 1'b1;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Register index of the winning requester.
    always_comb begin
        case (winner_s)
            2'd0:    win_addr_s = addr[4:0];
            2'd1:    win_addr_s = addr[9:5];
            2'd2:    win_addr_s = addr[14:10];
            2'd3:    win_addr_s = addr[19:15];
            default: win_addr_s = 5'd0;
        endcase
    end

    // Next-state and output register logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        card_d    = card_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        rvalid_d  = rvalid_q;
        err_d     = err_q;
        timeout_d = 1'b0;
`ifdef RDARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    gnt_d   = 4'b0001 << winner_s;
                    rid_d   = winner_s;
                    card_d  = win_addr_s;
                    state_d = SEL;
                end else begin
                    state_d = IDLE;
                end
            end
            SEL: begin
                rvalid_d = 1'b1;
                state_d  = RESP;
`ifdef RDARB_TIMEOUT_EN
                cnt_d    = 4'd0;
`endif
                // Indices 16-31 have no backing register: flag and return zero.
                if (card_q[4]) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    rdata_d = mux_out;
                    err_d   = 1'b0;
                end
            end
            RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    err_d    = 1'b0;
                    gnt_d    = 4'd0;
                    ptr_d    = rid_q + 2'd1;
                    state_d  = IDLE;
                end else begin
`ifdef RDARB_TIMEOUT_EN
                    if (cnt_q == 4'd15) begin
                        rvalid_d  = 1'b0;
                        err_d     = 1'b0;
                        gnt_d     = 4'd0;
                        ptr_d     = rid_q + 2'd1;
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
`else
                    state_d = RESP;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= 4'd0;
            card_q    <= 5'd0;
            rdata_q   <= 32'd0;
            rid_q     <= 2'd0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
`ifdef RDARB_TIMEOUT_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            card_q    <= card_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
`ifdef RDARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign card    = card_q;
    assign gnt     = gnt_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign err     = err_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a transaction-level reference model.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [19:0] addr;
    logic        rready;
    logic [31:0] mux_out;
    logic [4:0]  card;
    logic [3:0]  gnt;
    logic [31:0] rdata;
    logic        rvalid;
    logic [1:0]  rid;
    logic        err;
    logic        timeout;

    logic [31:0] mem [16];
    int n_vec = 0;
    int n_bad = 0;

    regfile_read_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .rready(rready),
        .mux_out(mux_out), .card(card), .gnt(gnt), .rdata(rdata),
        .rvalid(rvalid), .rid(rid), .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Out-of-range selects return garbage from the mux so a missing zero is visible.
    assign mux_out = card[4] ? 32'hFFFF_FFFF : mem[card[3:0]];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding read, tracked by owner and age since grant.
    int          m_owner, m_age, m_stall;
    logic [1:0]  m_ptr, m_rid;
    logic [4:0]  m_card;
    logic [31:0] m_rdata;
    logic        m_err, m_to;

    initial begin
        m_owner = -1; m_age = 0; m_stall = 0; m_ptr = 2'd0; m_rid = 2'd0;
        m_card = 5'd0; m_rdata = 32'd0; m_err = 1'b0; m_to = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1; m_age = 0; m_stall = 0; m_ptr = 2'd0; m_rid = 2'd0;
                m_card = 5'd0; m_rdata = 32'd0; m_err = 1'b0; m_to = 1'b0;
            end else begin
                m_to = 1'b0;
                if (m_owner < 0) begin
                    for (int k = 0; k < 4; k++) begin
                        if (m_owner < 0 && req[(int'(m_ptr) + k) % 4]) begin
                            m_owner = (int'(m_ptr) + k) % 4;
                        end
                    end
                    if (m_owner >= 0) begin
                        m_age  = 0;
                        m_card = addr[5*m_owner +: 5];
                        m_rid  = 2'(m_owner);
                    end
                end else if (m_age == 0) begin
                    m_age   = 1;
                    m_stall = 0;
                    m_err   = (m_card >= 5'd16);
                    m_rdata = (m_card >= 5'd16) ? 32'd0 : mem[m_card[3:0]];
                end else if (rready) begin
                    m_ptr   = 2'(m_owner + 1);
                    m_owner = -1;
                    m_err   = 1'b0;
                end else begin
                    m_stall++;
`ifdef RDARB_TIMEOUT_EN
                    if (m_stall == 16) begin
                        m_ptr   = 2'(m_owner + 1);
                        m_owner = -1;
                        m_err   = 1'b0;
                        m_to    = 1'b1;
                    end
`endif
                end
            end
        end
    end

    // Cycle-by-cycle compare of every output against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("gnt",     gnt,     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("rvalid",  rvalid,  (m_owner >= 0 && m_age == 1) ? 32'd1 : 32'd0);
            check("card",    card,    m_card);
            check("rdata",   rdata,   m_rdata);
            check("rid",     rid,     m_rid);
            check("err",     err,     m_err);
            check("timeout", timeout, m_to);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rvalid(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (rvalid) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: rvalid never rose, expected within 30 cycles", nm);
        end
    endtask

    int          exp_rid [5] = '{0, 1, 2, 3, 0};
    logic [4:0]  idx4    [4] = '{5'd3, 5'd7, 5'd9, 5'd12};

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
        mem[5] = 32'hDEAD_BEEF;
        rst = 1'b1; req = 4'd0; addr = 20'd0; rready = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        check("rst_gnt", gnt, 32'd0);
        check("rst_rvalid", rvalid, 32'd0);
        check("rst_card", card, 32'd0);
        rst = 1'b0;

        // Single read from requester 0.
        addr[4:0] = 5'd5; req = 4'b0001; rready = 1'b1;
        tick();
        check("t27_gnt", gnt, 32'h1);
        req = 4'b0000;
        wait_rvalid("t27_wait");
        check("t27_rdata", rdata, 32'hDEAD_BEEF);
        check("t27_rid", rid, 32'd0);
        check("t27_err", err, 32'd0);
        tick();
        check("t27_rvalid_drop", rvalid, 32'd0);

        // All four requesting: rotation from ptr=0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) addr[5*i +: 5] = idx4[i];
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rvalid("t28_wait");
            check("t28_rid", rid, exp_rid[k]);
            check("t28_gnt", gnt, 32'd1 << exp_rid[k]);
            check("t28_rdata", rdata, mem[idx4[exp_rid[k]][3:0]]);
        end
        #1 req = 4'b0000;

        // Out-of-range index.
        tick();
        addr[14:10] = 5'd20; req = 4'b0100;
        wait_rvalid("t29_wait");
        check("t29_err", err, 32'd1);
        check("t29_rdata", rdata, 32'd0);
        check("t29_rid", rid, 32'd2);
        #1 req = 4'b0000;

        // Back-pressure for 10 cycles with input churn mid-flight.
        tick();
        rready = 1'b0; addr[9:5] = 5'd9; req = 4'b0010;
        wait_rvalid("t30_wait");
        #1 req = 4'b0001; addr[9:5] = 5'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t30_rvalid", rvalid, 32'd1);
            check("t30_rdata", rdata, mem[9]);
            check("t30_gnt", gnt, 32'h2);
        end
        req = 4'b0000; rready = 1'b1;
        tick();
        check("t30_done", rvalid, 32'd0);
        check("t30_timeout", timeout, 32'd0);

        // Never accepting the response.
        rready = 1'b0; addr[19:15] = 5'd4; req = 4'b1000;
        wait_rvalid("t31_wait");
        #1 req = 4'b0000;
`ifdef RDARB_TIMEOUT_EN
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                tick();
                if (timeout) seen = 1'b1;
            end
            check("t31_timeout_seen", seen, 32'd1);
            check("t31_rvalid", rvalid, 32'd0);
            req = 4'b1001; rready = 1'b1;
            wait_rvalid("t31_next");
            check("t31_next_rid", rid, 32'd0);
            #1 req = 4'b0000;
        end
`else
        repeat (40) tick();
        check("t31_hold_rvalid", rvalid, 32'd1);
        check("t31_hold_timeout", timeout, 32'd0);
        rready = 1'b1;
        tick();
`endif

        // Reset while a response is pending.
        tick();
        rready = 1'b0; addr[9:5] = 5'd9; req = 4'b0010;
        wait_rvalid("t32_wait");
        #1 rst = 1'b1; req = 4'b1111;
        tick();
        check("t32_gnt", gnt, 32'd0);
        check("t32_rvalid", rvalid, 32'd0);
        check("t32_card", card, 32'd0);
        check("t32_rdata", rdata, 32'd0);
        check("t32_rid", rid, 32'd0);
        rst = 1'b0;
        tick();
        check("t32_ptr0", gnt, 32'h1);
        req = 4'b0000; rready = 1'b1;
        wait_rvalid("t32_final");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
